// File: rtl/crc8_frame_tx_if.sv
// Bundle for crc8_frame_tx: byte intake, generator bit feed/result and the framed TX stream.
// The master side is whatever drives bytes and answers as the CRC generator.
interface crc8_frame_tx_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       gen_data;
    logic       gen_valid;
    logic       gen_last;
    logic [7:0] crc_in;
    logic       crc_done;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_last;
    logic       frame_done;
    logic       crc_err;

    modport master (
        output byte_in, byte_valid, byte_last, crc_in, crc_done,
        input  byte_ready, gen_data, gen_valid, gen_last,
        input  tx_bit, tx_valid, tx_last, frame_done, crc_err
    );

    modport slave (
        input  byte_in, byte_valid, byte_last, crc_in, crc_done,
        output byte_ready, gen_data, gen_valid, gen_last,
        output tx_bit, tx_valid, tx_last, frame_done, crc_err
    );
endinterface

// File: rtl/crc8_frame_tx.sv
// Serialises message bytes MSB-first to a CRC-8 generator and a TX stream,
// then appends the generator's CRC to the TX stream to close the frame.
//
// state     | meaning
// WAIT_BYTE | idle or frame held open between bytes, byte_ready=1
// SHIFT     | driving one message bit per cycle to generator and TX
// WAIT_CRC  | message done, waiting on crc_done with a timeout
// CRC_OUT   | driving the latched CRC, MSB first, on TX only
module crc8_frame_tx #(
    parameter int CRC_TIMEOUT = 8,
    parameter int TIMER_W     = 4
) (
    input logic           clk,
    input logic           rst,
    crc8_frame_tx_if.slave bus
);
    typedef enum logic [1:0] {WAIT_BYTE, SHIFT, WAIT_CRC, CRC_OUT} state_t;

    localparam logic [TIMER_W-1:0] TMR_LOAD = TIMER_W'(CRC_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [7:0]         sh_q, sh_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [TIMER_W-1:0] tmr_q, tmr_d;
    logic               err_d;
    logic               accept;

    logic ready_q, gdata_q, gvalid_q, glast_q, tbit_q, tvalid_q, tlast_q, err_q;
    logic ready_d, gdata_d, gvalid_d, glast_d, tbit_d, tvalid_d, tlast_d;

    assign accept = bus.byte_valid && ready_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        tmr_d   = tmr_q;
        err_d   = 1'b0;
        case (state_q)
            WAIT_BYTE: begin
                if (accept) begin
                    sh_d    = bus.byte_in;
                    last_d  = bus.byte_last;
                    cnt_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != 3'd0) begin
                    sh_d  = {sh_q[6:0], 1'b0};
                    cnt_d = cnt_q - 3'd1;
                end else if (last_q) begin
                    tmr_d   = TMR_LOAD;
                    state_d = WAIT_CRC;
                end else if (accept) begin
                    // next byte lands straight behind bit0, no bubble
                    sh_d    = bus.byte_in;
                    last_d  = bus.byte_last;
                    cnt_d   = 3'd7;
                end else begin
                    state_d = WAIT_BYTE;
                end
            end
            WAIT_CRC: begin
                if (bus.crc_done) begin
                    sh_d    = bus.crc_in;
                    cnt_d   = 3'd7;
                    state_d = CRC_OUT;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    state_d = WAIT_BYTE;
                end else begin
                    tmr_d = tmr_q - TIMER_W'(1);
                end
            end
            CRC_OUT: begin
                if (cnt_q != 3'd0) begin
                    sh_d  = {sh_q[6:0], 1'b0};
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = WAIT_BYTE;
                end
            end
            default: state_d = WAIT_BYTE;
        endcase

        // outputs are decoded from next-state values so they register in step with the state
        ready_d  = (state_d == WAIT_BYTE) || (state_d == SHIFT && cnt_d == 3'd0 && !last_d);
        gvalid_d = (state_d == SHIFT);
        gdata_d  = gvalid_d && sh_d[7];
        glast_d  = gvalid_d && cnt_d == 3'd0 && last_d;
        tvalid_d = gvalid_d || (state_d == CRC_OUT);
        tbit_d   = tvalid_d && sh_d[7];
        tlast_d  = (state_d == CRC_OUT) && cnt_d == 3'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= WAIT_BYTE;
            sh_q     <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            tmr_q    <= '0;
            ready_q  <= 1'b1;
            gdata_q  <= 1'b0;
            gvalid_q <= 1'b0;
            glast_q  <= 1'b0;
            tbit_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            tmr_q    <= tmr_d;
            ready_q  <= ready_d;
            gdata_q  <= gdata_d;
            gvalid_q <= gvalid_d;
            glast_q  <= glast_d;
            tbit_q   <= tbit_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            err_q    <= err_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.gen_data   = gdata_q;
    assign bus.gen_valid  = gvalid_q;
    assign bus.gen_last   = glast_q;
    assign bus.tx_bit     = tbit_q;
    assign bus.tx_valid   = tvalid_q;
    assign bus.tx_last    = tlast_q;
    assign bus.frame_done = tlast_q;
    assign bus.crc_err    = err_q;
endmodule

// File: tb/tb_crc8_frame_tx.sv
// Bench for crc8_frame_tx: table vectors, random frames against a bytewise CRC-8 model,
// plus timeout and mid-frame reset sequences. The bench also plays the CRC generator.
module tb_crc8_frame_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    crc8_frame_tx_if bus();

    crc8_frame_tx #(.CRC_TIMEOUT(8), .TIMER_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] msg;
        int          n;
        int          gap;
        int          dly;
        bit          spur;
        logic [39:0] exp_tx;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frame_id = 0;

    bit tx_q[$];
    bit gen_q[$];
    int tx_last_cnt, tx_last_pos, tx_last_tick, fd_cnt, fd_mis, err_cnt, err_tick;
    int gl_cnt, gl_pos, gl_tick, first_gen, bubbles, mirror_err, tail_ready;
    int crc_wait, cur_dly, acc_tick;
    bit cur_spur, tail;
    logic post_ready, post_err, post_txv;
    logic [7:0] ref_crc;
    logic [7:0] msg [4];

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int k = 0; k < 8; k++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL frame %0d %s: got %0h expected %0h", frame_id, name, act, exp);
        end
    endtask

    task automatic clear_mon();
        tx_q.delete();
        gen_q.delete();
        tx_last_cnt = 0; tx_last_pos = 0; tx_last_tick = 0; fd_cnt = 0; fd_mis = 0;
        err_cnt = 0; err_tick = 0; gl_cnt = 0; gl_pos = 0; gl_tick = 0; first_gen = -1;
        bubbles = 0; mirror_err = 0; tail_ready = 0; crc_wait = -1; tail = 0; acc_tick = 0;
    endtask

    task automatic idle_in();
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        bus.byte_last  = 1'($urandom);
    endtask

    task automatic present(input int i, input int n);
        bus.byte_in    = msg[i];
        bus.byte_last  = (i == n - 1);
        bus.byte_valid = 1'b1;
    endtask

    // one clock: sample everything at the falling edge, then act as the generator
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.frame_done || bus.crc_err) tail = 0;
        if (tail && bus.byte_ready) tail_ready++;
        if (bus.tx_valid) tx_q.push_back(bus.tx_bit);
        if (bus.gen_valid) begin
            gen_q.push_back(bus.gen_data);
            if (first_gen < 0) first_gen = cyc;
            if (bus.tx_valid !== 1'b1 || bus.tx_bit !== bus.gen_data) mirror_err++;
        end else if (first_gen >= 0 && gl_cnt == 0) begin
            bubbles++;
        end
        if (bus.tx_last) begin
            tx_last_cnt++;
            tx_last_pos  = tx_q.size();
            tx_last_tick = cyc;
        end
        if (bus.frame_done) fd_cnt++;
        if (bus.frame_done !== bus.tx_last) fd_mis++;
        if (bus.crc_err) begin
            err_cnt++;
            err_tick = cyc;
        end
        bus.crc_done = 1'b0;
        bus.crc_in   = 8'($urandom);
        if (cur_spur && bus.gen_valid) bus.crc_done = 1'($urandom_range(0, 1));
        if (crc_wait > 0) begin
            crc_wait--;
            if (crc_wait == 0) begin
                bus.crc_done = 1'b1;
                bus.crc_in   = ref_crc;
                crc_wait     = -1;
            end
        end
        if (bus.gen_last) begin
            gl_cnt++;
            gl_pos   = gen_q.size();
            gl_tick  = cyc;
            crc_wait = (cur_dly > 0) ? cur_dly : -1;
        end
    endtask

    task automatic run_frame(input int n, input int g, input int d, input bit spur);
        int i = 0;
        int wait_cnt = 0;
        int guard = 0;
        logic rdy, vld;
        clear_mon();
        cur_dly  = d;
        cur_spur = spur;
        ref_crc  = 8'h00;
        for (int k = 0; k < n; k++) ref_crc = crc8_upd(ref_crc, msg[k]);
        present(0, n);
        while (fd_cnt == 0 && err_cnt == 0 && guard < 400) begin
            rdy = bus.byte_ready;
            vld = bus.byte_valid;
            tick();
            guard++;
            if (vld && rdy && i < n) begin
                if (i == 0) acc_tick = cyc;
                i++;
                if (i == n) begin
                    idle_in();
                    tail = 1;
                end else if (g == 0) begin
                    present(i, n);
                end else begin
                    idle_in();
                    wait_cnt = 7 + g;
                end
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) present(i, n);
            end
        end
        check("frame_ends_in_budget", guard < 400, 1);
        tick();
        post_ready = bus.byte_ready;
        post_err   = bus.crc_err;
        post_txv   = bus.tx_valid;
        cur_spur   = 0;
    endtask

    task automatic check_frame(input int n, input int g, input int d, input logic [39:0] exp_tx);
        logic [39:0] got_tx = '0;
        logic [39:0] got_gen = '0;
        logic [7:0]  res = 8'h00;
        int exp_len = 8 * (n + 1);
        foreach (tx_q[k])  got_tx  = {got_tx[38:0], tx_q[k]};
        foreach (gen_q[k]) got_gen = {got_gen[38:0], gen_q[k]};
        check("tx_len", tx_q.size(), exp_len);
        check("tx_bits", got_tx, exp_tx);
        check("gen_len", gen_q.size(), 8 * n);
        check("gen_bits", got_gen, exp_tx >> 8);
        check("gen_last_count", gl_cnt, 1);
        check("gen_last_pos", gl_pos, 8 * n);
        check("tx_last_count", tx_last_cnt, 1);
        check("tx_last_pos", tx_last_pos, exp_len);
        check("frame_done_count", fd_cnt, 1);
        check("frame_done_vs_tx_last", fd_mis, 0);
        check("crc_err_count", err_cnt, 0);
        check("gen_tx_mirror", mirror_err, 0);
        check("mid_frame_bubbles", bubbles, g * (n - 1));
        check("latency", tx_last_tick - acc_tick, 8 * n + 7 + d + g * (n - 1));
        check("ready_low_in_tail", tail_ready, 0);
        check("ready_after_frame", post_ready, 1);
        for (int k = 0; k < n; k++) res = crc8_upd(res, msg[k]);
        res = crc8_upd(res, got_tx[7:0]);
        check("residue", res, 8'h00);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'h4869,     2, 0, 1, 1'b0, 40'h4869EB};
        vecs[1] = '{32'h00,       1, 0, 1, 1'b0, 40'h0000};
        vecs[2] = '{32'h4869,     2, 3, 1, 1'b0, 40'h4869EB};
        vecs[3] = '{32'hFF,       1, 0, 4, 1'b0, 40'hFFF3};
        vecs[4] = '{32'h01,       1, 1, 8, 1'b1, 40'h0107};
        vecs[5] = '{32'h123456,   3, 2, 2, 1'b1, 40'h1234567C};
        vecs[6] = '{32'h4869,     2, 0, 1, 1'b1, 40'h4869EB};

        cur_spur = 0; cur_dly = 0;
        clear_mon();
        idle_in();
        bus.crc_done = 1'b0;
        bus.crc_in   = 8'h00;
        rst = 1'b0;
        tick();
        tick();
        check("reset_outputs", {bus.byte_ready, bus.gen_data, bus.gen_valid, bus.gen_last,
               bus.tx_bit, bus.tx_valid, bus.tx_last, bus.frame_done, bus.crc_err}, 9'b1_0000_0000);
        rst = 1'b1;
        tick();

        foreach (vecs[v]) begin
            frame_id = v;
            for (int k = 0; k < vecs[v].n; k++)
                msg[k] = vecs[v].msg[8 * (vecs[v].n - 1 - k) +: 8];
            run_frame(vecs[v].n, vecs[v].gap, vecs[v].dly, vecs[v].spur);
            check_frame(vecs[v].n, vecs[v].gap, vecs[v].dly, vecs[v].exp_tx);
        end

        // random frames: expected stream is message followed by its bytewise CRC-8
        for (int r = 0; r < 20; r++) begin
            int n, g, d;
            logic [39:0] exp;
            logic [7:0]  c;
            frame_id = 100 + r;
            n = $urandom_range(1, 4);
            g = $urandom_range(0, 3);
            d = $urandom_range(1, 8);
            exp = '0;
            c = 8'h00;
            for (int k = 0; k < n; k++) begin
                msg[k] = 8'($urandom);
                exp = {exp[31:0], msg[k]};
                c = crc8_upd(c, msg[k]);
            end
            exp = {exp[31:0], c};
            run_frame(n, g, d, 1'($urandom));
            check_frame(n, g, d, exp);
        end

        // crc_done never arrives: timeout after 8 WAIT_CRC cycles, no CRC bits
        frame_id = 200;
        msg[0] = 8'hA5;
        run_frame(1, 0, 0, 1'b0);
        check("timeout_err_count", err_cnt, 1);
        check("timeout_err_timing", err_tick - gl_tick, 9);
        check("timeout_tx_len", tx_q.size(), 8);
        check("timeout_tx_last", tx_last_cnt, 0);
        check("timeout_frame_done", fd_cnt, 0);
        check("timeout_err_pulse", post_err, 0);
        check("timeout_ready_after", post_ready, 1);
        check("timeout_tx_idle_after", post_txv, 0);

        // reset after five message bits abandons the frame
        frame_id = 300;
        clear_mon();
        msg[0] = 8'h48;
        present(0, 2);
        for (int k = 0; k < 40 && tx_q.size() < 5; k++) tick();
        check("reset_mid_bits_seen", tx_q.size(), 5);
        idle_in();
        rst = 1'b0;
        tick();
        check("reset_mid_outputs", {bus.byte_ready, bus.gen_data, bus.gen_valid, bus.gen_last,
               bus.tx_bit, bus.tx_valid, bus.tx_last, bus.frame_done, bus.crc_err}, 9'b1_0000_0000);
        rst = 1'b1;
        tick();
        check("reset_stays_idle", {bus.byte_ready, bus.gen_valid, bus.tx_valid}, 3'b100);
        frame_id = 301;
        msg[0] = 8'h48;
        msg[1] = 8'h69;
        run_frame(2, 0, 1, 1'b0);
        check_frame(2, 0, 1, 40'h4869EB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/crc8_frame_tx.md
Name: crc8_frame_tx

Overview:
- Upstream feeder and downstream consumer for crc8_serial_gen.
- Accepts message bytes on a valid/ready interface and serialises them MSB-first onto the generator's bit interface (data_in/data_valid/last_bit).
- Mirrors the same bits onto a serial TX stream, then waits for crc_done, captures crc_out and appends the 8 CRC bits to the TX stream.
- Result is a complete framed bitstream: message followed by CRC-8 (poly 0x07, init 0x00).

Parameters:
- CRC_TIMEOUT, 8, max cycles spent in WAIT_CRC before abandoning the frame.
- TIMER_W, 4, width of the timeout counter; must satisfy 2^TIMER_W > CRC_TIMEOUT.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset; sampled on rising clk.
- byte_in  input  8  message byte.
- byte_valid  input  1  byte_in valid.
- byte_last  input  1  byte_in is the final message byte; qualified by byte_valid.
- byte_ready  output  1  block can accept a byte this cycle.
- gen_data  output  1  bit to generator data_in.
- gen_valid  output  1  to generator data_valid.
- gen_last  output  1  to generator last_bit.
- crc_in  input  8  from generator crc_out.
- crc_done  input  1  from generator crc_done.
- tx_bit  output  1  serial frame bit.
- tx_valid  output  1  tx_bit valid.
- tx_last  output  1  final bit of frame (CRC bit 0).
- frame_done  output  1  one-cycle pulse with tx_last.
- crc_err  output  1  one-cycle pulse on CRC timeout.

Behaviour:
- All outputs are registered.
- When rst=0 at a rising edge:
  - State goes to WAIT_BYTE, frame closed, counters cleared.
  - All outputs go to 0 except byte_ready, which goes to 1.
- Reset mid-frame abandons the frame with no partial CRC emitted.
- Byte acceptance: a byte is taken on a rising edge where byte_valid && byte_ready.
- WAIT_BYTE:
  - byte_ready=1, gen_valid=0, tx_valid=0.
  - On accept: load shift register, latch byte_last, bit index=7, go to SHIFT.
- SHIFT (8 cycles per byte):
  - gen_data = tx_bit = current bit, MSB first; gen_valid = tx_valid = 1.
  - Byte accepted at edge T: bit7 is driven in cycle T+1, bit0 in cycle T+8.
  - gen_last=1 only on bit0 of a byte latched with byte_last=1.
  - tx_last stays 0 throughout SHIFT.
- Back-to-back bytes: byte_ready=1 during the bit0 cycle when the current byte is not last.
  - If a byte is accepted at that edge, its bit7 follows in the very next cycle, with no bubble.
  - Otherwise the block goes to WAIT_BYTE with the frame held open; gen_valid stays 0 until the next byte arrives.
  - The generator holds its state while data_valid=0.
- Last byte done: after bit0 of the last byte, go to WAIT_CRC. byte_ready=0 from the last byte's acceptance until the frame ends.
- WAIT_CRC:
  - gen_valid=0, tx_valid=0; the timer increments each cycle.
  - On an edge with crc_done=1: latch crc_in and go to CRC_OUT. crc_done is honoured even in the first WAIT_CRC cycle.
  - If the timer reaches CRC_TIMEOUT without crc_done: crc_err=1 for one cycle, go to WAIT_BYTE, frame closed, no CRC bits emitted.
- crc_done outside WAIT_CRC is ignored.
- CRC_OUT (8 cycles):
  - tx_bit = latched CRC, MSB first; tx_valid=1; gen_valid=0.
  - On CRC bit0: tx_last=1 and frame_done=1, then go to WAIT_BYTE with byte_ready=1 the next cycle.
- byte_valid while byte_ready=0 is not a transfer; the upstream source must hold its data.
- Minimum frame latency, byte accept to tx_last, for N bytes with crc_done at the first WAIT_CRC edge: 8N + 1 + 8 cycles.
- Bit-level and byte-level counters wrap only via explicit reload; no arithmetic overflow is permitted.

Test Plan:
1. Bytes 0x48 (last=0) and 0x69 (last=1) back-to-back, with a generator model (poly 0x07, init 0x00):
   - gen stream is 16 valid bits, 0x4869, with gen_last on the 16th.
   - tx stream is 24 valid bits, 0x4869EB, with tx_last and frame_done on the 24th.
   - Feeding 0x4869EB through the generator gives residue 0x00.
2. Single byte 0x00 with last=1 -> tx 16 bits 0x0000, tx_last on bit 16, crc_err=0.
3. "Hi" with byte_valid low for 3 cycles between bytes:
   - gen_valid and tx_valid are low for at least 3 cycles mid-frame.
   - Appended CRC is still 0xEB.
4. crc_done tied 0 with CRC_TIMEOUT=8:
   - crc_err pulses once, 8 cycles after entering WAIT_CRC.
   - No CRC bits and no tx_last are emitted; byte_ready=1 on the next cycle.
5. rst=0 for one edge after 5 message bits:
   - All outputs are 0 and byte_ready=1 the following cycle.
   - A subsequent "Hi" frame yields 0x4869EB.
6. Spurious crc_done during SHIFT is ignored.
   - crc_done asserted in the first WAIT_CRC cycle -> first CRC bit on tx in the next cycle.
